// File: rtl/apb_timer_slave.sv
`default_nettype none
// ============================================================================
// apb_timer_slave : APB slave exposing a 32-bit down-counter timer with
//                   auto-reload, sticky expiry flag and level interrupt.
// Revision       : 1.0
// ============================================================================
module apb_timer_slave #(
  parameter int PSEL_INDEX = 0
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  input  logic        Penable,
  input  logic        Pwrite,
  output logic [31:0] Prdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        exp_q, exp_d;

  logic        sel;
  logic        access_valid;
  logic        wr_en;
  logic        exp_set;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign sel          = Pselx[PSEL_INDEX];
  assign unused_bits  = ^{Paddr[31:4], Paddr[1:0], Pselx};
  // Only an enable that directly follows a setup cycle is a real access.
  assign access_valid = (state_q == SETUP) && sel && Penable;
  assign wr_en        = access_valid && write_q;
  assign exp_set      = ctrl_q[0] && (count_q == 32'd0);
  assign irq          = exp_q && ctrl_q[2];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel && !Penable) state_d = SETUP;
      SETUP: begin
        if (!sel)         state_d = IDLE;
        else if (Penable) state_d = ACCESS;
        else              state_d = SETUP;
      end
      ACCESS:  state_d = (sel && !Penable) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    if (state_d == SETUP) begin
      addr_d  = Paddr[3:2];
      write_d = Pwrite;
      wdata_d = Pwdata;
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    if (ctrl_q[0]) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[1]) count_d   = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end
    // Bus writes override the timer's own update; expiry beats a clear.
    if (wr_en) begin
      case (addr_q)
        ADDR_CTRL:   ctrl_d = wdata_q[2:0];
        ADDR_LOAD: begin
          load_d  = wdata_q;
          count_d = wdata_q;
        end
        ADDR_STATUS: if (wdata_q[0] && !exp_set) exp_d = 1'b0;
        default:     ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr_q)
      ADDR_CTRL:   rd_mux = {29'd0, ctrl_q};
      ADDR_LOAD:   rd_mux = load_q;
      ADDR_COUNT:  rd_mux = count_q;
      ADDR_STATUS: rd_mux = {31'd0, exp_q};
      default:     rd_mux = 32'd0;
    endcase
    Prdata = (access_valid && !write_q) ? rd_mux : 32'd0;
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q <= IDLE;
      addr_q  <= 2'd0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      ctrl_q  <= 3'd0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_slave.sv
`default_nettype none
// ============================================================================
// tb_apb_timer_slave : directed and randomized APB traffic against a
//                      cycle-level register model of the timer.
// Revision           : 1.0
// ============================================================================
module tb_apb_timer_slave;

  localparam int         SEL      = 1;
  localparam logic [2:0] SEL_MASK = 3'b010;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Prdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural view of the timer registers
  logic [2:0]  m_ctrl;
  logic [31:0] m_load;
  logic [31:0] m_count;
  logic        m_exp;
  logic [31:0] exp_rd;

  apb_timer_slave #(.PSEL_INDEX(SEL)) dut (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .Pselx   (Pselx),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Prdata  (Prdata),
    .irq     (irq)
  );

  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ctrl  = 3'd0;
    m_load  = 32'd0;
    m_count = 32'd0;
    m_exp   = 1'b0;
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {31'd0, m_exp};
    endcase
  endfunction

  // One clock of timer behaviour, with an optional committed bus write.
  task automatic model_edge(input logic wr, input logic [1:0] a, input logic [31:0] d);
    logic [2:0]  nc;
    logic [31:0] nl;
    logic [31:0] ncnt;
    logic        ne;
    logic        expired;
    nc = m_ctrl; nl = m_load; ncnt = m_count; ne = m_exp;
    expired = m_ctrl[0] && (m_count == 32'd0);
    if (m_ctrl[0] && !expired) ncnt = m_count - 32'd1;
    if (expired) begin
      ne = 1'b1;
      if (m_ctrl[1]) ncnt = m_load;
      else           nc[0] = 1'b0;
    end
    if (wr) begin
      if (a == 2'd0) nc = d[2:0];
      if (a == 2'd1) begin nl = d; ncnt = d; end
      if (a == 2'd3 && d[0] && !expired) ne = 1'b0;
    end
    m_ctrl = nc; m_load = nl; m_count = ncnt; m_exp = ne;
  endtask

  task automatic cycle(input string tag, input logic wr, input logic [1:0] a, input logic [31:0] d);
    @(negedge Hclk);
    check(tag, Prdata, exp_rd);
    check("irq", {31'd0, irq}, {31'd0, m_exp & m_ctrl[2]});
    @(posedge Hclk);
    model_edge(wr, a, d);
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input logic [1:0] a);
    return ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
  endfunction

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      Pselx   = 3'($urandom_range(0, 7)) & ~SEL_MASK;
      Penable = 1'($urandom_range(0, 1));
      Pwrite  = 1'($urandom_range(0, 1));
      Paddr   = $urandom();
      Pwdata  = $urandom();
      exp_rd  = 32'd0;
      cycle("idle_prdata", 1'b0, 2'd0, 32'd0);
    end
  endtask

  // Transfer addressed to a different slave: must be invisible here.
  task automatic other_slave();
    Pselx   = 3'($urandom_range(0, 7)) & ~SEL_MASK;
    Penable = 1'b0;
    Pwrite  = 1'($urandom_range(0, 1));
    Paddr   = $urandom();
    Pwdata  = $urandom();
    exp_rd  = 32'd0;
    cycle("oth_setup", 1'b0, 2'd0, 32'd0);
    Penable = 1'b1;
    cycle("oth_access", 1'b0, 2'd0, 32'd0);
  endtask

  // Address/data are scrambled in the access phase: the captured values rule.
  task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
    Pselx   = SEL_MASK | 3'($urandom_range(0, 7));
    Penable = 1'b0;
    Pwrite  = 1'b1;
    Paddr   = mk_addr(a);
    Pwdata  = d;
    exp_rd  = 32'd0;
    cycle("wr_setup", 1'b0, 2'd0, 32'd0);
    Penable = 1'b1;
    Paddr   = $urandom();
    Pwdata  = $urandom();
    cycle("wr_access", 1'b1, a, d);
  endtask

  task automatic apb_read(input logic [1:0] a);
    Pselx   = SEL_MASK | 3'($urandom_range(0, 7));
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = mk_addr(a);
    Pwdata  = $urandom();
    exp_rd  = 32'd0;
    cycle("rd_setup", 1'b0, 2'd0, 32'd0);
    Penable = 1'b1;
    Paddr   = $urandom();
    exp_rd  = m_reg(a);
    cycle($sformatf("rd_reg%0d", a), 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    int guard;
    int op;
    logic [1:0]  ra;
    logic [31:0] rd;

    Hreset = 1'b1; Pselx = 3'd0; Paddr = 32'd0; Pwdata = 32'd0;
    Penable = 1'b0; Pwrite = 1'b0; exp_rd = 32'd0;
    model_reset();
    repeat (2) @(posedge Hclk);
    #1;
    check("reset_prdata", Prdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    Hreset = 1'b0;
    bus_idle(1);
    for (int i = 0; i < 4; i++) apb_read(2'(i));

    // One-shot countdown with interrupt enabled
    apb_write(2'd1, 32'd5);
    apb_write(2'd0, 32'd5);
    for (int i = 0; i < 4; i++) apb_read(2'd2);
    bus_idle(2);
    apb_read(2'd3);
    apb_read(2'd0);

    // Auto-reload, interrupt masked
    apb_write(2'd0, 32'd0);
    apb_write(2'd3, 32'd1);
    apb_write(2'd1, 32'd2);
    apb_write(2'd0, 32'd3);
    for (int i = 0; i < 5; i++) apb_read(2'd2);
    apb_read(2'd3);
    apb_write(2'd0, 32'd0);

    // Status read then write-1-to-clear with IE set
    apb_write(2'd0, 32'd4);
    bus_idle(1);
    apb_read(2'd3);
    apb_write(2'd3, 32'd1);
    bus_idle(1);
    apb_read(2'd3);

    // Clear lands on the very cycle the counter expires: expiry wins
    apb_write(2'd1, 32'd6);
    apb_write(2'd0, 32'd1);
    guard = 0;
    while (m_count != 32'd1 && guard < 50) begin
      bus_idle(1);
      guard++;
    end
    check("expiry_wait", guard, (guard < 50) ? guard : 0);
    apb_write(2'd3, 32'd1);
    bus_idle(1);
    apb_read(2'd3);

    // LOAD=0 with reload keeps expiring every enabled cycle
    apb_write(2'd1, 32'd0);
    apb_write(2'd0, 32'd7);
    apb_write(2'd3, 32'd1);
    apb_read(2'd3);
    apb_write(2'd0, 32'd0);

    // Enable without setup must not write LOAD
    bus_idle(1);
    Pselx = SEL_MASK; Penable = 1'b1; Pwrite = 1'b1;
    Paddr = 32'h4; Pwdata = 32'hAA; exp_rd = 32'd0;
    cycle("viol_prdata", 1'b0, 2'd0, 32'd0);
    bus_idle(1);
    apb_read(2'd1);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      ra = 2'($urandom_range(0, 3));
      case (op)
        0, 1: begin
          if (ra == 2'd1)      rd = 32'($urandom_range(0, 12));
          else if (ra == 2'd0) rd = 32'($urandom_range(0, 7));
          else                 rd = $urandom();
          apb_write(ra, rd);
        end
        2, 3:    apb_read(ra);
        4:       other_slave();
        default: bus_idle($urandom_range(1, 4));
      endcase
      if ($urandom_range(0, 1) == 0) bus_idle(1);
    end

    // Asynchronous reset in the access phase of a LOAD write
    apb_write(2'd1, 32'd0);
    apb_write(2'd0, 32'd1);
    bus_idle(2);
    apb_write(2'd0, 32'd4);
    bus_idle(1);
    Pselx = SEL_MASK; Penable = 1'b0; Pwrite = 1'b1;
    Paddr = 32'h4; Pwdata = 32'h1234; exp_rd = 32'd0;
    cycle("rst_wr_setup", 1'b0, 2'd0, 32'd0);
    Penable = 1'b1;
    #2;
    Hreset = 1'b1;
    #1;
    check("rst_async_prdata", Prdata, 32'd0);
    check("rst_async_irq", {31'd0, irq}, 32'd0);
    model_reset();
    @(posedge Hclk);
    #1;
    Hreset = 1'b0;
    bus_idle(2);
    for (int i = 0; i < 4; i++) apb_read(2'(i));
    apb_write(2'd1, 32'h1234);
    apb_read(2'd1);
    bus_idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_timer_slave.md
APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001 Parameter: PSEL_INDEX, default 0, selects which bit of Pselx addresses this slave (legal values 0..2).
REQ-002 Hclk  input  1  single clock; all state updates on its rising edge.
REQ-003 Hreset  input  1  reset, asynchronous and active-high.
REQ-004 Pselx  input  3  APB slave selects from the bridge; only bit PSEL_INDEX is used.
REQ-005 Paddr  input  32  APB address; only Paddr[3:2] is decoded, all other bits ignored.
REQ-006 Pwdata  input  32  APB write data.
REQ-007 Penable  input  1  APB enable (access phase).
REQ-008 Pwrite  input  1  1 = write, 0 = read.
REQ-009 Prdata  output  32  APB read data.
REQ-010 irq  output  1  timer interrupt, level.

Function
REQ-011 Register map by Paddr[3:2]:
- 0 = CTRL[2:0]: bit0 EN, bit1 RELOAD, bit2 IE; bits 31:3 read 0.
- 1 = LOAD[31:0].
- 2 = COUNT[31:0], read-only.
- 3 = STATUS[0] EXP, write-1-to-clear; bits 31:1 read 0.
REQ-012 Internal APB phase FSM with states IDLE, SETUP and ACCESS; sel denotes Pselx[PSEL_INDEX].
REQ-013 IDLE->SETUP when sel && !Penable.
REQ-014 SETUP->ACCESS when sel && Penable.
REQ-015 SETUP->IDLE when !sel.
REQ-016 SETUP stays in SETUP when sel && !Penable.
REQ-017 ACCESS->SETUP when sel && !Penable (back-to-back transfer); otherwise ACCESS->IDLE.
REQ-018 A Penable seen while the FSM is in IDLE (no setup cycle) is a protocol violation; it is ignored, with no write and Prdata = 0.
REQ-019 Address, Pwrite and Pwdata are captured on the clock edge that ends SETUP; the access executes on the captured values.
REQ-020 A write commits on the rising edge that ends the ACCESS cycle; the new value is visible from the next cycle.
REQ-021 Prdata equals the addressed register, combinationally, during a valid ACCESS read cycle; it is 0 at all other times, including during writes.
REQ-022 Counter behaviour when EN=1 and COUNT>0: COUNT decrements by 1 each cycle.
REQ-023 Counter behaviour when EN=1 and COUNT==0:
- EXP is set to 1.
- If RELOAD=1, COUNT<=LOAD.
- If RELOAD=0, EN is cleared to 0 and COUNT holds at 0.
REQ-024 When EN=0, COUNT holds its value.
REQ-025 A write to LOAD also sets COUNT<=Pwdata in the same edge; this has priority over decrement and reload.
REQ-026 Writes to COUNT are ignored.
REQ-027 Write of 1 to STATUS bit0 clears EXP; a write of 0 has no effect.
REQ-028 If an EXP set and a clear occur in the same cycle, the set wins.
REQ-029 If a CTRL write and a hardware EN clear (REQ-023) occur in the same cycle, the CTRL write wins.
REQ-030 COUNT arithmetic is 32-bit unsigned; it never wraps below 0.
REQ-031 A LOAD value of 0 with RELOAD=1 sets EXP on every enabled cycle.
REQ-032 irq = EXP && IE, driven from registers with no combinational path from APB inputs.

Reset
REQ-033 Hreset asserted forces the following immediately, regardless of Hclk: FSM=IDLE, CTRL=0, LOAD=0, COUNT=0, EXP=0, Prdata=0, irq=0.
REQ-034 Hreset asserted mid-transfer aborts the transfer; no register write occurs.
REQ-035 After Hreset deasserts, the first valid setup cycle is accepted normally.

Verification
REQ-036 Write LOAD=5, then CTRL=0x5 -> COUNT reads 5,4,3,2,1,0 on successive cycles; EXP=1 and irq=1 on the cycle after COUNT=0; EN reads 0 afterwards.
REQ-037 LOAD=2, CTRL=0x3 -> COUNT sequence 2,1,0,2,1,0; EXP set each expiry; irq stays 0 (IE=0).
REQ-038 Read STATUS with EXP=1 -> Prdata=0x1 only in the ACCESS cycle and 0 in SETUP; then write STATUS=0x1 -> EXP=0, irq=0.
REQ-039 Write-1-clear to STATUS in the same cycle COUNT hits 0 with EN=1 -> EXP remains 1.
REQ-040 Penable=1 with sel=1 but no preceding setup cycle, Pwrite=1, Paddr=0x4, Pwdata=0xAA -> LOAD unchanged; Prdata=0.
REQ-041 Assert Hreset during the ACCESS cycle of a LOAD=0x1234 write -> LOAD=0 and all outputs 0 immediately; no write after release.
